// File: rtl/vga_sync_to_count.sv
// ----------------------------------------------------------------------------
// vga_sync_to_count
//
// Receive-side counterpart of the VGA sync generator. Rebuilds the column/row
// counters from the incoming HSync/VSync and runs a lock state machine that
// checks frame periods are exact. When VGA_HSYNC_CHECK_EN is defined, it also
// checks that line periods are exact.
//
// Optional feature macro: VGA_HSYNC_CHECK_EN (line-period check on HSync).
//
// Ports:
//   i_Clk          pixel clock, everything is synchronous to it
//   i_Rst          synchronous reset, active-high
//   i_HSync        horizontal sync (used only with VGA_HSYNC_CHECK_EN)
//   i_VSync        vertical sync
//   o_Col_Count    regenerated column, 0..TOTAL_COLS-1
//   o_Row_Count    regenerated row, 0..TOTAL_ROWS-1
//   o_Active       locked and inside the visible window
//   o_Locked       lock state machine is in LOCKED
//   o_Frame_Start  1-cycle pulse: counters realigned to (0,0) while LOCKED
//   o_Timing_Err   1-cycle pulse: period violation detected while LOCKED
//
// There is no valid/ready handshake. All outputs are valid on every cycle.
// The pulse outputs are registered, so they line up with the counter and
// state values that the same clock edge produces.
// ----------------------------------------------------------------------------
module vga_sync_to_count #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_HSync,
    input  logic       i_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Active,
    output logic       o_Locked,
    output logic       o_Frame_Start,
    output logic       o_Timing_Err
);

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_ACQUIRE  = 2'd1,
        S_LOCKED   = 2'd2
    } state_t;

    localparam logic [9:0] LP_COL_LAST    = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] LP_ROW_LAST    = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] LP_ACT_COLS    = 10'(ACTIVE_COLS);
    localparam logic [9:0] LP_ACT_ROWS    = 10'(ACTIVE_ROWS);
    localparam logic [7:0] LP_LOCK_FRAMES = 8'(LOCK_FRAMES);

    state_t     r_State;
    state_t     w_State_Next;
    logic [9:0] r_Col;
    logic [9:0] r_Row;
    logic [9:0] w_Col_Next;
    logic [9:0] w_Row_Next;
    logic [7:0] r_Good;
    logic [7:0] w_Good_Next;
    logic       r_VSync_Prev;
    logic       r_Frame_Start;
    logic       r_Timing_Err;
    logic       w_Frame_Start;
    logic       w_Timing_Err;
    logic       w_V_Err;
    logic       w_V_Rise;
    logic       w_At_End;

    // The previous-sync register resets to 1. If VSync is already high at
    // reset release, it is not treated as a rising edge.
    assign w_V_Rise = i_VSync & ~r_VSync_Prev;
    assign w_At_End = (r_Col == LP_COL_LAST) && (r_Row == LP_ROW_LAST);

    // Counter advance. A VSync rise realigns the counters and takes priority
    // over the normal increment.
    always_comb begin
        w_Col_Next = r_Col + 10'd1;
        w_Row_Next = r_Row;
        if (w_V_Rise) begin
            w_Col_Next = '0;
            w_Row_Next = '0;
        end else if (r_Col == LP_COL_LAST) begin
            w_Col_Next = '0;
            w_Row_Next = (r_Row == LP_ROW_LAST) ? 10'd0 : r_Row + 10'd1;
        end
    end

`ifdef VGA_HSYNC_CHECK_EN
    localparam logic [11:0] LP_LINE_LEN = 12'(TOTAL_COLS);

    logic        r_HSync_Prev;
    logic [11:0] r_Line_Cnt;
    logic        r_Line_Primed;
    logic        w_H_Rise;
    logic        w_H_Err;

    assign w_H_Rise = i_HSync & ~r_HSync_Prev;
    // r_Line_Cnt equals the spacing in clocks since the previous HSync rise.
    assign w_H_Err  = (r_State == S_LOCKED) && w_H_Rise && r_Line_Primed &&
                      (r_Line_Cnt != LP_LINE_LEN);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_HSync_Prev  <= 1'b1;
            r_Line_Cnt    <= '0;
            r_Line_Primed <= 1'b0;
        end else begin
            r_HSync_Prev <= i_HSync;
            if (w_H_Rise) begin
                r_Line_Cnt <= 12'd1;
            end else if (r_Line_Cnt != 12'hFFF) begin
                r_Line_Cnt <= r_Line_Cnt + 12'd1;
            end
            // On entry to ACQUIRE, the next HSync rise only primes the spacing.
            if ((w_State_Next == S_ACQUIRE) && (r_State != S_ACQUIRE)) begin
                r_Line_Primed <= 1'b0;
            end else if (w_H_Rise) begin
                r_Line_Primed <= 1'b1;
            end
        end
    end
`else
    logic w_unused_hsync;
    assign w_unused_hsync = i_HSync;
`endif

    // Lock state machine: next state, good-frame count and pulse requests.
    always_comb begin
        w_State_Next  = r_State;
        w_Good_Next   = r_Good;
        w_Frame_Start = 1'b0;
        w_V_Err       = 1'b0;
        w_Timing_Err  = 1'b0;
        case (r_State)
            S_UNLOCKED: begin
                if (w_V_Rise) begin
                    w_State_Next = S_ACQUIRE;
                    w_Good_Next  = '0;
                end
            end
            S_ACQUIRE: begin
                if (w_V_Rise && w_At_End) begin
                    if (r_Good + 8'd1 == LP_LOCK_FRAMES) begin
                        w_State_Next  = S_LOCKED;
                        w_Good_Next   = '0;
                        w_Frame_Start = 1'b1;
                    end else begin
                        w_Good_Next = r_Good + 8'd1;
                    end
                end else if (w_V_Rise || w_At_End) begin
                    w_Good_Next = '0;
                end
            end
            S_LOCKED: begin
                if (w_V_Rise && w_At_End) begin
                    w_Frame_Start = 1'b1;
                end else if (w_V_Rise) begin
                    w_V_Err      = 1'b1;
                    w_State_Next = S_ACQUIRE;
                    w_Good_Next  = '0;
                end else if (w_At_End) begin
                    w_V_Err      = 1'b1;
                    w_State_Next = S_UNLOCKED;
                    w_Good_Next  = '0;
                end
            end
            default: begin
                w_State_Next = S_UNLOCKED;
                w_Good_Next  = '0;
            end
        endcase
        w_Timing_Err = w_V_Err;
`ifdef VGA_HSYNC_CHECK_EN
        // When both checks fail in the same cycle, there is one error pulse
        // and the VSync check decides the next state.
        if (w_H_Err) begin
            w_Timing_Err = 1'b1;
            if (!w_V_Err) begin
                w_State_Next = S_ACQUIRE;
                w_Good_Next  = '0;
            end
        end
`endif
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State       <= S_UNLOCKED;
            r_Col         <= '0;
            r_Row         <= '0;
            r_Good        <= '0;
            r_VSync_Prev  <= 1'b1;
            r_Frame_Start <= 1'b0;
            r_Timing_Err  <= 1'b0;
        end else begin
            r_State       <= w_State_Next;
            r_Col         <= w_Col_Next;
            r_Row         <= w_Row_Next;
            r_Good        <= w_Good_Next;
            r_VSync_Prev  <= i_VSync;
            r_Frame_Start <= w_Frame_Start;
            r_Timing_Err  <= w_Timing_Err;
        end
    end

    assign o_Col_Count   = r_Col;
    assign o_Row_Count   = r_Row;
    assign o_Locked      = (r_State == S_LOCKED);
    assign o_Active      = (r_State == S_LOCKED) && (r_Col < LP_ACT_COLS) &&
                           (r_Row < LP_ACT_ROWS);
    assign o_Frame_Start = r_Frame_Start;
    assign o_Timing_Err  = r_Timing_Err;

endmodule

// File: tb/tb_vga_sync_to_count.sv
`timescale 1ns/1ps
module tb_vga_sync_to_count;

    localparam int TC    = 10;
    localparam int TR    = 6;
    localparam int AC    = 8;
    localparam int AR    = 4;
    localparam int LF    = 2;
    localparam int FRAME = TC * TR;
    localparam int W     = 24;
`ifdef VGA_HSYNC_CHECK_EN
    localparam bit HCHK = 1'b1;
`else
    localparam bit HCHK = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       hsync;
    logic       vsync;
    logic [9:0] col;
    logic [9:0] row;
    logic       active;
    logic       locked;
    logic       fs;
    logic       err;

    always #5 clk = ~clk;

    vga_sync_to_count #(
        .TOTAL_COLS (TC),
        .TOTAL_ROWS (TR),
        .ACTIVE_COLS(AC),
        .ACTIVE_ROWS(AR),
        .LOCK_FRAMES(LF)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_HSync      (hsync),
        .i_VSync      (vsync),
        .o_Col_Count  (col),
        .o_Row_Count  (row),
        .o_Active     (active),
        .o_Locked     (locked),
        .o_Frame_Start(fs),
        .o_Timing_Err (err)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int n_fs     = 0;
    int n_err    = 0;
    int n_act    = 0;

    // ---------------- reference model ----------------
    // Position in the frame is a single linear index 0..FRAME-1.
    // The lock status is a pair of flags: locked and acquiring.
    int m_pos     = 0;
    int m_good    = 0;
    int m_cyc     = 0;
    int m_last_h  = 0;
    bit m_locked  = 1'b0;
    bit m_acq     = 1'b0;
    bit m_pv      = 1'b1;
    bit m_ph      = 1'b1;
    bit m_primed  = 1'b0;
    int h_phase   = 0;

    task automatic model_step(input bit r, input bit v, input bit h, output logic [W-1:0] e);
        bit vr;
        bit hr;
        bit at_end;
        bit fs_e;
        bit err_e;
        bit v_err;
        bit h_err;
        bit was_acq;
        int spacing;
        logic [9:0] e_col;
        logic [9:0] e_row;
        logic e_act;
        fs_e  = 1'b0;
        err_e = 1'b0;
        if (r) begin
            m_pos    = 0;
            m_locked = 1'b0;
            m_acq    = 1'b0;
            m_good   = 0;
            m_pv     = 1'b1;
            m_ph     = 1'b1;
            m_primed = 1'b0;
        end else begin
            vr      = v && !m_pv;
            hr      = h && !m_ph;
            at_end  = (m_pos == FRAME - 1);
            spacing = m_cyc - m_last_h;
            was_acq = m_acq;
            v_err   = 1'b0;
            h_err   = HCHK && m_locked && hr && m_primed && (spacing != TC);
            if (m_locked) begin
                if (vr && at_end) begin
                    fs_e = 1'b1;
                end else if (vr) begin
                    v_err = 1'b1; m_locked = 1'b0; m_acq = 1'b1; m_good = 0;
                end else if (at_end) begin
                    v_err = 1'b1; m_locked = 1'b0; m_acq = 1'b0; m_good = 0;
                end
                if (h_err && !v_err) begin
                    m_locked = 1'b0; m_acq = 1'b1; m_good = 0;
                end
                err_e = v_err || h_err;
            end else if (m_acq) begin
                if (vr && at_end) begin
                    m_good++;
                    if (m_good == LF) begin
                        m_locked = 1'b1; m_acq = 1'b0; m_good = 0; fs_e = 1'b1;
                    end
                end else if (vr || at_end) begin
                    m_good = 0;
                end
            end else if (vr) begin
                m_acq  = 1'b1;
                m_good = 0;
            end
            if (m_acq && !was_acq) m_primed = 1'b0;
            else if (hr) m_primed = 1'b1;
            if (hr) m_last_h = m_cyc;
            m_pos = vr ? 0 : (m_pos + 1) % FRAME;
            m_pv  = v;
            m_ph  = h;
        end
        m_cyc++;
        e_col = 10'(m_pos % TC);
        e_row = 10'(m_pos / TC);
        e_act = m_locked && ((m_pos % TC) < AC) && ((m_pos / TC) < AR);
        e = {e_col, e_row, e_act, m_locked, fs_e, err_e};
    endtask

    // ---------------- driver tasks ----------------
    // HSync is a periodic 2-cycle pulse with period TC. Setting hold_h
    // stretches one period to TC+1.
    task automatic tick(input bit r, input bit v, input bit hold_h);
        logic [W-1:0] e;
        bit h;
        h = (h_phase < 2);
        if (!hold_h) h_phase = (h_phase + 1) % TC;
        rst   = r;
        vsync = v;
        hsync = h;
        model_step(r, v, h, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // A frame of len clocks that starts with a VSync rise.
    task automatic frame(input int len, input int hold_at);
        int vh;
        vh = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) tick(1'b0, i < vh, i == hold_at);
    endtask

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        forever begin
            @(posedge clk);
            #1;
            a = {col, row, active, locked, fs, err};
            if (fs === 1'b1) n_fs++;
            if (err === 1'b1) n_err++;
            if (active === 1'b1) n_act++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t: got col=%0d row=%0d act=%b lock=%b fs=%b err=%b expected col=%0d row=%0d act=%b lock=%b fs=%b err=%b",
                             $time, a[23:14], a[13:4], a[3], a[2], a[1], a[0],
                             e[23:14], e[13:4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int len;
        int sel;
        int hold;
        rst   = 1'b1;
        vsync = 1'b1;
        hsync = 1'b0;

        // Reset with VSync held high, then release while still high: no edge.
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b1, 1'b0);
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        check_eq("reset_no_fs", n_fs, 0);
        check_eq("reset_no_err", n_err, 0);
        check_eq("reset_unlocked", int'(locked), 0);

        // Three exact frames bring the design to lock.
        c0 = n_fs;
        repeat (3) frame(60, -1);
        check_eq("lock_fs_count", n_fs - c0, 1);
        check_eq("lock_locked", int'(locked), 1);

        // A VSync rise that arrives one clock early drops lock. Two exact frames relock.
        c0 = n_err;
        frame(60, -1);
        frame(59, -1);
        frame(60, -1);
        check_eq("short_frame_err", n_err - c0, 1);
        check_eq("short_frame_unlocked", int'(locked), 0);
        frame(60, -1);
        frame(60, -1);
        check_eq("short_frame_relock", int'(locked), 1);

        // VSync stops: an error fires at the frame end, and the counters wrap.
        c0 = n_err;
        repeat (70) tick(1'b0, 1'b0, 1'b0);
        check_eq("vsync_stop_err", n_err - c0, 1);
        check_eq("vsync_stop_unlocked", int'(locked), 0);

        // Relock, then count visible cycles in one locked frame.
        c0 = n_fs;
        repeat (3) frame(60, -1);
        check_eq("relock_fs_count", n_fs - c0, 1);
        c0 = n_act;
        frame(60, -1);
        check_eq("active_per_frame", n_act - c0, AC * AR);

        // One HSync period stretched to 11 clocks while locked.
        c0 = n_err;
        frame(60, 30);
        frame(60, -1);
        check_eq("hsync_glitch_err", n_err - c0, HCHK ? 1 : 0);
        check_eq("hsync_glitch_locked", int'(locked), HCHK ? 0 : 1);

        // Randomised frame lengths, HSync stretches and resets.
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) len = 60;
            else if (sel == 6) len = 59;
            else if (sel == 7) len = 61;
            else len = $urandom_range(20, 80);
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(5, len - 1) : -1;
            if (sel == 9) begin
                repeat ($urandom_range(1, 2)) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            end
            frame(len, hold);
        end

        repeat (3) tick(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
